us_ping_ranger: RTL and testbench
=================================

Name: us_ping_ranger

Overview:
- Upstream stage for navigation: one instance per ultrasonic sensor (front, back, side-front, side-back).
- Drives the trigger pulse onto the sensor's single bidirectional signal pin, then releases the pin and times the returned echo.
- Converts the echo width to centimetres and presents a registered distance plus a valid strobe to the navigation logic.
- Free-runs while enabled at a fixed ranging period.

Parameters:
CLK_PER_US, 50, CLK cycles per microsecond (50 MHz board clock)
TRIG_US, 5, trigger pulse width in us
ECHO_WAIT_US, 1000, max us from trigger release to echo rise
ECHO_MAX_US, 20000, max echo high time in us before timeout
US_PER_CM, 58, echo us per cm of range (round trip)
PERIOD_US, 60000, trigger-to-trigger period in us

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
EN  in  1  level; 1 = continuous ranging
US_SIG  inout  1  sensor signal pin; driven 1 during trigger, else Z
DIST_CM  out  9  last measured distance in cm, saturating at 511
VALID  out  1  one-cycle strobe when DIST_CM/TIMEOUT update
TIMEOUT  out  1  1 = last measurement had no echo or over-long echo
BUSY  out  1  1 while a measurement cycle is in progress

Behaviour:
- One clock domain: CLK. Reset is synchronous and active-low (RST_N), sampled on the CLK rising edge.
- Reset values: DIST_CM=0, VALID=0, TIMEOUT=0, BUSY=0, US_SIG released (Z), FSM=IDLE, all counters 0.
- Reset takes effect mid-measurement: the pin is released in the same cycle, and no VALID is issued for the aborted cycle.
- US_SIG drive: US_SIG = drv ? 1 : Z; drv is registered.
- Echo input: read through a 2-flop synchronizer, which adds 2 cycles of input latency. Edges are detected on the synchronized value.
- Microsecond tick: prescaler counts 0..CLK_PER_US-1 and pulses tick at the wrap. The prescaler restarts at 0 on every FSM state change.
- FSM:
  - IDLE: BUSY=0. If EN=1, go to TRIG.
  - TRIG: drv=1, BUSY=1. After TRIG_US ticks, drv=0 and go to WAIT_RISE.
  - WAIT_RISE: pin released. Synchronized rising edge -> ECHO; clear us/cm counters. ECHO_WAIT_US ticks with no rise -> DONE with TIMEOUT result.
  - ECHO: each tick increments the us sub-counter 0..US_PER_CM-1; at its wrap, DIST_acc increments, saturating at 511. Synchronized falling edge -> DONE with measured result. ECHO_MAX_US ticks with no fall -> DONE with TIMEOUT result.
  - DONE (1 cycle): load DIST_CM = DIST_acc (or 511 if timeout), TIMEOUT = timeout flag, VALID=1. Go to GAP.
  - GAP: wait until PERIOD_US ticks have elapsed since TRIG entry, then go to IDLE. The period counter runs from TRIG entry through DONE.
- Partial cm (remainder us) is truncated. Example: echo 579 us -> 9 cm.
- EN deasserted mid-cycle: the current measurement completes through DONE/GAP. IDLE then holds until EN=1.
- Echo already high in WAIT_RISE (no rising edge): treated as no rise, so it ends in timeout.
- DIST_CM and TIMEOUT hold their values between VALID strobes.
- VALID is never asserted in back-to-back cycles.

Optional Feature:
- Macro: US_MEDIAN3_EN.
- Defined: a 3-entry history of non-timeout distances (shift on each non-timeout DONE).
  - Once 3 entries are held, DIST_CM = median of the 3. Before that, DIST_CM = raw value.
  - Timeout results output 511/TIMEOUT=1 and are not pushed into the history.
  - VALID moves 1 cycle later (median register stage).
  - History clears on reset.
- Undefined: raw distance only, VALID in the DONE cycle as above.

Test Plan:
- Reset/idle: RST_N=0 for 5 cycles with EN=1 -> DIST_CM=0, VALID=0, US_SIG=Z. Release -> US_SIG=1 for exactly 250 cycles (5 us), then Z.
- Nominal echo: bench model raises US_SIG 750 us after release, high for 580 us -> single VALID, DIST_CM=10, TIMEOUT=0. Next trigger at exactly 60000 us period.
- Saturation/truncation: echo 579 us -> DIST_CM=9. Echo 19000 us -> DIST_CM=327. Run with US_PER_CM=1, echo 600 us -> DIST_CM=511, TIMEOUT=0.
- No echo: pin never rises -> VALID 1000 us after trigger release, DIST_CM=511, TIMEOUT=1. Stuck-high echo of 25000 us -> TIMEOUT=1 at 20000 us.
- Reset mid-ECHO: RST_N low for 1 cycle at 300 us into echo -> outputs return to reset values, no VALID, pin Z. Next cycle starts with a fresh trigger.
- US_MEDIAN3_EN: echoes 580, 1160, 290 us -> DIST_CM 10, 20, then 10 (median of 10/20/5). Timeout in between does not change the history.

Source files
------------

// File: rtl/us_ping_ranger.sv
// us_ping_ranger: ultrasonic ranger for one sensor on a single bidirectional pin.
// Drives the trigger pulse, releases the pin, times the echo and reports the
// range in cm (truncated, saturating at 511) with a one-cycle VALID strobe.
// Ranging repeats every PERIOD_US while EN is high.
//
// Ports:
//   CLK      system clock
//   RST_N    synchronous active-low reset
//   EN       1 = continuous ranging
//   US_SIG   sensor pin, driven 1 during trigger, otherwise Z
//   DIST_CM  last distance in cm (511 on timeout or saturation)
//   VALID    one-cycle strobe when DIST_CM/TIMEOUT update
//   TIMEOUT  last measurement had no echo or an over-long echo
//   BUSY     measurement cycle in progress
//
// Optional build macro US_MEDIAN3_EN: DIST_CM becomes the median of the last
// three non-timeout results (raw until three are held); VALID is one cycle later.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for EN
// TRIG      | driving the trigger pulse
// WAIT_RISE | pin released, waiting for echo rising edge
// ECHO      | echo high, counting us and cm
// DONE      | one cycle, result loaded
// GAP       | waiting out the trigger-to-trigger period

module us_ping_ranger #(
   parameter int CLK_PER_US   = 50,
   parameter int TRIG_US      = 5,
   parameter int ECHO_WAIT_US = 1000,
   parameter int ECHO_MAX_US  = 20000,
   parameter int US_PER_CM    = 58,
   parameter int PERIOD_US    = 60000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       EN,
   inout  wire        US_SIG,
   output logic [8:0] DIST_CM,
   output logic       VALID,
   output logic       TIMEOUT,
   output logic       BUSY
);

   localparam int PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int ST_MAX0 = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
   localparam int ST_MAX  = (ST_MAX0 > ECHO_MAX_US) ? ST_MAX0 : ECHO_MAX_US;
   localparam int ST_W    = $clog2(ST_MAX + 1);
   localparam int SUB_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
   localparam int PER_CYC = PERIOD_US * CLK_PER_US;
   localparam int PER_W   = $clog2(PER_CYC);
   localparam logic [8:0] DIST_SAT = 9'd511;

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_RISE, S_ECHO, S_DONE, S_GAP
   } state_t;

   state_t            state, state_nxt;
   logic [PRE_W-1:0]  pre_cnt;
   logic [ST_W-1:0]   st_cnt, st_load;
   logic [PER_W-1:0]  per_cnt;
   logic [SUB_W-1:0]  sub_q, sub_nxt;
   logic [8:0]        acc_q, acc_nxt;
   logic [8:0]        raw_q;
   logic              to_q;
   logic              drv;
   logic              sync1, sync2, sync3;
   logic              tick, st_end, rise, fall, done_to;

   // Releasing on RST_N directly frees the pin in the reset cycle itself.
   assign US_SIG = (drv && RST_N) ? 1'b1 : 1'bz;

   assign tick   = (pre_cnt == PRE_W'(CLK_PER_US - 1));
   assign st_end = tick && (st_cnt == '0);
   assign rise   = sync2 && !sync3;
   assign fall   = !sync2 && sync3;
   assign BUSY   = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      done_to   = 1'b0;
      case (state)
         S_IDLE:      if (EN) state_nxt = S_TRIG;
         S_TRIG:      if (st_end) state_nxt = S_WAIT_RISE;
         S_WAIT_RISE: begin
            if (rise) begin
               state_nxt = S_ECHO;
            end else if (st_end) begin
               state_nxt = S_DONE;
               done_to   = 1'b1;
            end
         end
         S_ECHO: begin
            if (fall) begin
               state_nxt = S_DONE;
            end else if (st_end) begin
               state_nxt = S_DONE;
               done_to   = 1'b1;
            end
         end
         S_DONE:      state_nxt = S_GAP;
         S_GAP:       if (per_cnt == '0) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Per-state tick budget, loaded as N-1 so expiry lands on the Nth tick.
   always_comb begin
      st_load = '0;
      case (state_nxt)
         S_TRIG:      st_load = ST_W'(TRIG_US - 1);
         S_WAIT_RISE: st_load = ST_W'(ECHO_WAIT_US - 1);
         S_ECHO:      st_load = ST_W'(ECHO_MAX_US - 1);
         default:     st_load = '0;
      endcase
   end

   always_comb begin
      sub_nxt = sub_q;
      acc_nxt = acc_q;
      if (state == S_WAIT_RISE && rise) begin
         sub_nxt = '0;
         acc_nxt = '0;
      end else if (state == S_ECHO && tick) begin
         if (sub_q == SUB_W'(US_PER_CM - 1)) begin
            sub_nxt = '0;
            if (acc_q != DIST_SAT) acc_nxt = acc_q + 9'd1;
         end else begin
            sub_nxt = sub_q + SUB_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         pre_cnt <= '0;
         st_cnt  <= '0;
         per_cnt <= '0;
         sub_q   <= '0;
         acc_q   <= '0;
         raw_q   <= '0;
         to_q    <= 1'b0;
         drv     <= 1'b0;
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync3   <= 1'b0;
      end else begin
         state <= state_nxt;
         sync1 <= US_SIG;
         sync2 <= sync1;
         sync3 <= sync2;
         drv   <= (state_nxt == S_TRIG);
         sub_q <= sub_nxt;
         acc_q <= acc_nxt;

         if (state_nxt != state) begin
            pre_cnt <= '0;
            st_cnt  <= st_load;
         end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick && st_cnt != '0) st_cnt <= st_cnt - ST_W'(1);
         end

         // Counted in clocks, two short so the IDLE cycle before the next
         // trigger is absorbed and trigger-to-trigger is exactly PERIOD_US.
         if (state_nxt == S_TRIG && state != S_TRIG)
            per_cnt <= PER_W'(PER_CYC - 2);
         else if (per_cnt != '0)
            per_cnt <= per_cnt - PER_W'(1);

         // acc_nxt includes a wrap that coincides with the falling edge.
         if (state_nxt == S_DONE && state != S_DONE) begin
            raw_q <= done_to ? DIST_SAT : acc_nxt;
            to_q  <= done_to;
         end
      end
   end

`ifdef US_MEDIAN3_EN
   logic [8:0] hist0, hist1, med_q, lo, hi, med3;
   logic [1:0] hist_n;
   logic       med_to_q, med_vld_q;

   always_comb begin
      lo   = (raw_q < hist0) ? raw_q : hist0;
      hi   = (raw_q < hist0) ? hist0 : raw_q;
      med3 = (hi < hist1) ? hi : hist1;
      if (med3 < lo) med3 = lo;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hist0     <= '0;
         hist1     <= '0;
         hist_n    <= '0;
         med_q     <= '0;
         med_to_q  <= 1'b0;
         med_vld_q <= 1'b0;
      end else begin
         med_vld_q <= (state == S_DONE);
         if (state == S_DONE) begin
            med_to_q <= to_q;
            if (to_q) begin
               med_q <= DIST_SAT;
            end else begin
               med_q  <= (hist_n >= 2'd2) ? med3 : raw_q;
               hist1  <= hist0;
               hist0  <= raw_q;
               if (hist_n != 2'd3) hist_n <= hist_n + 2'd1;
            end
         end
      end
   end

   assign DIST_CM = med_q;
   assign TIMEOUT = med_to_q;
   assign VALID   = med_vld_q;
`else
   assign DIST_CM = raw_q;
   assign TIMEOUT = to_q;
   assign VALID   = (state == S_DONE);
`endif

endmodule

// File: tb/tb_us_ping_ranger.sv
// Bench for us_ping_ranger with scaled timing parameters (2 clocks/us,
// 2400 us period) so every ranging scenario fits a short run.
module tb_us_ping_ranger;

   localparam int CPU   = 2;
   localparam int TRIG  = 5;
   localparam int WAITU = 100;
   localparam int MAXU  = 2200;
   localparam int UPC   = 4;
   localparam int PER   = 2400;
`ifdef US_MEDIAN3_EN
   localparam int MED_LAT = 1;
`else
   localparam int MED_LAT = 0;
`endif

   typedef struct {
      int d;     // echo start, us after release (-1 = no echo)
      int w;     // echo high time, us
      int raw;   // expected DIST_CM, raw build
      int med;   // expected DIST_CM, median build
      int to;    // expected TIMEOUT
      int per;   // 1 = check trigger period against previous trigger
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       oe = 1'b0;
   logic       val = 1'b0;
   wire        us_sig;
   logic [8:0] dist_cm;
   logic       valid, timeout, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_trig = 0;
   int t_prev = 0;
   int stray = 0;
   bit ok;
   vec_t vecs[10];

   assign us_sig = oe ? val : 1'bz;

   us_ping_ranger #(
      .CLK_PER_US(CPU), .TRIG_US(TRIG), .ECHO_WAIT_US(WAITU),
      .ECHO_MAX_US(MAXU), .US_PER_CM(UPC), .PERIOD_US(PER)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .EN(en), .US_SIG(us_sig),
      .DIST_CM(dist_cm), .VALID(valid), .TIMEOUT(timeout), .BUSY(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_trig(input string name, input int bound, output bit found);
      found = 0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); @(negedge clk);
         if (valid) stray++;
         if (us_sig === 1'b1) begin
            found = 1;
            t_trig = cyc;
            break;
         end
      end
      chk(name, found, 1);
   endtask

   // Entered at the negedge where the trigger is first seen high.
   task automatic run_echo(input string tag, input int d, input int w,
                           input int exp_dist, input int exp_to);
      int hi, lat, exp_lat, bound;
      bit seen;
      hi = 1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); @(negedge clk);
         if (us_sig === 1'b1) hi++;
         else break;
      end
      chk({tag, "_trig_width"}, hi, TRIG * CPU);
      chk({tag, "_busy"}, int'(busy), 1);
      if (d < 0)        exp_lat = WAITU * CPU;
      else if (w > MAXU) exp_lat = (d + MAXU) * CPU + 3;
      else               exp_lat = (d + w) * CPU + 3;
      exp_lat += MED_LAT;
      bound = exp_lat + 200;
      oe = 1'b1;
      seen = 0;
      lat = 0;
      for (int kk = 0; kk < bound; kk++) begin
         val = (d >= 0) && (kk >= d * CPU) && (kk < (d + w) * CPU);
         @(posedge clk); @(negedge clk);
         if (valid) begin
            seen = 1;
            lat = kk + 1;
            break;
         end
      end
      chk({tag, "_valid_seen"}, int'(seen), 1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_dist"}, int'(dist_cm), exp_dist);
      chk({tag, "_timeout"}, int'(timeout), exp_to);
      oe = 1'b0;
      val = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({tag, "_valid_single"}, int'(valid), 0);
      chk({tag, "_dist_hold"}, int'(dist_cm), exp_dist);
   endtask

   initial begin
      //          d    w     raw  med  to per
      vecs[0] = '{75,  40,   10,  10,  0, 0};
      vecs[1] = '{75,  39,    9,   9,  0, 1};
      vecs[2] = '{20,  1310, 327, 10,  0, 1};
      vecs[3] = '{10,  2100, 511, 327, 0, 0};
      vecs[4] = '{-1,  0,    511, 511, 1, 0};
      vecs[5] = '{50,  2300, 511, 511, 1, 0};
      vecs[6] = '{30,  40,   10,  10,  0, 0};
      vecs[7] = '{30,  80,   20,  20,  0, 0};
      vecs[8] = '{-1,  0,    511, 511, 1, 0};
      vecs[9] = '{30,  20,   5,   10,  0, 0};

      // Reset with EN high
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_dist", int'(dist_cm), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pin_released", (us_sig === 1'b1) ? 1 : 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         t_prev = t_trig;
         wait_trig($sformatf("v%0d_trigger", i), PER * CPU + 100, ok);
         if (vecs[i].per != 0) chk($sformatf("v%0d_period", i), t_trig - t_prev, PER * CPU);
`ifdef US_MEDIAN3_EN
         run_echo($sformatf("v%0d", i), vecs[i].d, vecs[i].w, vecs[i].med, vecs[i].to);
`else
         run_echo($sformatf("v%0d", i), vecs[i].d, vecs[i].w, vecs[i].raw, vecs[i].to);
`endif
      end

      // EN dropped during trigger: measurement completes, then no new trigger
      wait_trig("en_trigger", PER * CPU + 100, ok);
      en = 1'b0;
`ifdef US_MEDIAN3_EN
      run_echo("en_off", 30, 40, 327, 0);
`else
      run_echo("en_off", 30, 40, 10, 0);
`endif
      hi_check: begin
         int hits;
         hits = 0;
         for (int i = 0; i < PER * CPU + 100; i++) begin
            @(posedge clk); @(negedge clk);
            if (us_sig === 1'b1) hits++;
         end
         chk("en_off_no_trigger", hits, 0);
      end
      chk("en_off_idle_busy", int'(busy), 0);
      en = 1'b1;
      wait_trig("en_on_trigger", 3, ok);

      // Reset in the middle of an echo
      rst_seq: begin
         int hi, vcount;
         hi = 1;
         for (int i = 0; i < 1000; i++) begin
            @(posedge clk); @(negedge clk);
            if (us_sig === 1'b1) hi++;
            else break;
         end
         chk("rst_echo_trig_width", hi, TRIG * CPU);
         oe = 1'b1;
         vcount = 0;
         for (int kk = 0; kk < (10 + 30) * CPU; kk++) begin
            val = (kk >= 10 * CPU);
            @(posedge clk); @(negedge clk);
            if (valid) vcount++;
         end
         chk("rst_echo_no_early_valid", vcount, 0);
         rst_n = 1'b0;
         oe = 1'b0;
         val = 1'b0;
         @(posedge clk); @(negedge clk);
         chk("mid_rst_valid", int'(valid), 0);
         chk("mid_rst_dist", int'(dist_cm), 0);
         chk("mid_rst_timeout", int'(timeout), 0);
         chk("mid_rst_busy", int'(busy), 0);
         chk("mid_rst_pin_released", (us_sig === 1'b1) ? 1 : 0, 0);
         rst_n = 1'b1;
         stray = 0;
         wait_trig("post_rst_trigger", 4, ok);
         chk("post_rst_no_valid", stray, 0);
      end

      for (int i = 6; i < 10; i++) begin
         if (i != 6) wait_trig($sformatf("v%0d_trigger", i), PER * CPU + 100, ok);
`ifdef US_MEDIAN3_EN
         run_echo($sformatf("v%0d", i), vecs[i].d, vecs[i].w, vecs[i].med, vecs[i].to);
`else
         run_echo($sformatf("v%0d", i), vecs[i].d, vecs[i].w, vecs[i].raw, vecs[i].to);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
